// File: rtl/vec_pack.sv
// vec_pack: packs vector-aligned bus beats (last beat of each vector partially used) into dense words.
// Optional macro VEC_PACK_KEEP_EN adds a dn_Keep byte-enable output.
module vec_pack #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] up_Vector,
  input  logic                 up_Valid,
  input  logic                 up_Last,
  output logic                 up_Ready,
  output logic [BUS_WIDTH-1:0] dn_Vector,
  output logic                 dn_Valid,
  output logic                 dn_Last,
  input  logic                 dn_Ready
`ifdef VEC_PACK_KEEP_EN
  ,
  output logic [BUS_WIDTH/8-1:0] dn_Keep
`endif
);

  localparam int BEATS = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int REM   = VECTOR_WIDTH - (BEATS - 1) * BUS_WIDTH;
  localparam int AW    = 2 * BUS_WIDTH;
  localparam int FW    = $clog2(AW);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW    = BUS_WIDTH / 8;

  localparam logic [FW-1:0]  BW_F      = FW'(BUS_WIDTH);
  localparam logic [FW-1:0]  REM_F     = FW'(REM);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state_p0, state_n;
  logic [AW-1:0]  acc_p0, acc_n;
  logic [FW-1:0]  fill_p0, fill_n;
  logic [BCW-1:0] beat_p0, beat_n;
  logic [FW-1:0]  nbits;
  logic           dn_hs;
  logic           up_hs;

  function automatic logic [BUS_WIDTH-1:0] low_ones(input logic [FW-1:0] n);
    logic [BUS_WIDTH-1:0] m;
    for (int i = 0; i < BUS_WIDTH; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic [KW-1:0] keep_mask(input logic [FW-1:0] n);
    logic [KW-1:0] k;
    int nb;
    nb = (int'(n) + 7) / 8;
    for (int i = 0; i < KW; i++) k[i] = (i < nb);
    return k;
  endfunction

  assign dn_Valid  = (state_p0 == RUN) ? (fill_p0 >= BW_F) : (fill_p0 != '0);
  assign dn_Last   = (state_p0 == FLUSH) && (fill_p0 != '0) && (fill_p0 <= BW_F);
  // In FLUSH the tail word is forced clean above the fill point.
  assign dn_Vector = (state_p0 == FLUSH) ? (acc_p0[BUS_WIDTH-1:0] & low_ones(fill_p0))
                                         : acc_p0[BUS_WIDTH-1:0];
  assign dn_hs     = dn_Valid && dn_Ready;
  assign up_Ready  = (state_p0 == RUN) && ((fill_p0 < BW_F) || dn_hs);
  assign up_hs     = up_Valid && up_Ready;

`ifdef VEC_PACK_KEEP_EN
  assign dn_Keep = !dn_Valid ? '0 : (dn_Last ? keep_mask(fill_p0) : '1);
`endif

  always_comb begin
    state_n = state_p0;
    acc_n   = acc_p0;
    fill_n  = fill_p0;
    beat_n  = beat_p0;
    nbits   = (beat_p0 == LAST_BEAT) ? REM_F : BW_F;

    if (dn_hs) begin
      if (dn_Last) begin
        acc_n  = '0;
        fill_n = '0;
      end else begin
        acc_n  = acc_p0 >> BUS_WIDTH;
        fill_n = fill_p0 - BW_F;
      end
    end

    // Append lands on top of whatever the concurrent drain left behind.
    if (up_hs) begin
      acc_n  = acc_n | ({{BUS_WIDTH{1'b0}}, up_Vector & low_ones(nbits)} << fill_n);
      fill_n = fill_n + nbits;
      if (up_Last) begin
        state_n = FLUSH;
        beat_n  = '0;
      end else begin
        beat_n = (beat_p0 == LAST_BEAT) ? '0 : beat_p0 + 1'b1;
      end
    end

    if ((state_p0 == FLUSH) && ((fill_p0 == '0) || (dn_hs && dn_Last))) begin
      state_n = RUN;
      beat_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= RUN;
      acc_p0   <= '0;
      fill_p0  <= '0;
      beat_p0  <= '0;
    end else begin
      state_p0 <= state_n;
      acc_p0   <= acc_n;
      fill_p0  <= fill_n;
      beat_p0  <= beat_n;
    end
  end

endmodule

// File: tb/tb_vec_pack.sv
// tb_vec_pack: randomized streams checked against a bit-queue packing model of vec_pack.
module tb_vec_pack;
  localparam int BW    = 128;
  localparam int VW    = 920;
  localparam int BEATS = (VW + BW - 1) / BW;
  localparam int REM   = VW - (BEATS - 1) * BW;
  localparam int KW    = BW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] up_Vector;
  logic          up_Valid;
  logic          up_Last;
  logic          up_Ready;
  logic [BW-1:0] dn_Vector;
  logic          dn_Valid;
  logic          dn_Last;
  logic          dn_Ready;
  logic [KW-1:0] dn_Keep_w;
`ifdef VEC_PACK_KEEP_EN
  logic [KW-1:0] dn_Keep;
  assign dn_Keep_w = dn_Keep;
`else
  assign dn_Keep_w = '0;
`endif

  vec_pack #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW)) dut (
    .clk(clk), .rst(rst),
    .up_Vector(up_Vector), .up_Valid(up_Valid), .up_Last(up_Last), .up_Ready(up_Ready),
    .dn_Vector(dn_Vector), .dn_Valid(dn_Valid), .dn_Last(dn_Last), .dn_Ready(dn_Ready)
`ifdef VEC_PACK_KEEP_EN
    , .dn_Keep(dn_Keep)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc, stall_lo, stall_hi;
  logic [BW-1:0] hold_v;
  bit have_hold;

  logic [BW-1:0] got_w[$];
  bit            got_l[$];
  logic [KW-1:0] got_k[$];
  logic [BW-1:0] exp_w[$];
  int            exp_tail;

  always @(negedge clk) begin
    if (!rst && dn_Valid && dn_Ready) begin
      got_w.push_back(dn_Vector);
      got_l.push_back(dn_Last);
      got_k.push_back(dn_Keep_w);
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [KW-1:0] exp_keep(input int nbits);
    logic [KW-1:0] k;
    for (int i = 0; i < KW; i++) k[i] = (i * 8 < nbits);
    return k;
  endfunction

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] d;
    for (int j = 0; j < BW; j++) d[j] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  // One clock: optional stall checks at negedge, then advance to just past the edge.
  task automatic step(output bit accepted);
    @(negedge clk);
    accepted = up_Valid && up_Ready;
    if (!dn_Ready && dn_Valid) begin
      if (have_hold) begin
        check("stall_hold", dn_Vector, hold_v);
        check("stall_upready", {{(BW-1){1'b0}}, up_Ready}, '0);
      end
      hold_v = dn_Vector;
      have_hold = 1'b1;
    end else begin
      have_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    dn_Ready = !(cyc >= stall_lo && cyc < stall_hi);
    if (!up_Valid) up_Vector = rand_word();
  endtask

  // gap < 0 means random 0..3 idle cycles between beats.
  task automatic run_stream(input string tag, input int nvec, input int nbeats,
                            input int gap, input int slo, input int shi, input int exp_count);
    logic [BW-1:0] beats[$];
    bit bitq[$];
    bit a;
    int to, nb, nw, g;
    logic [BW-1:0] w;
    beats.delete(); bitq.delete(); exp_w.delete();
    got_w.delete(); got_l.delete(); got_k.delete();
    if (nbeats <= 0) nbeats = nvec * BEATS;
    for (int b = 0; b < nbeats; b++) begin
      w = rand_word();
      beats.push_back(w);
      nb = ((b % BEATS) == BEATS - 1) ? REM : BW;
      for (int j = 0; j < nb; j++) bitq.push_back(w[j]);
    end
    nw = (bitq.size() + BW - 1) / BW;
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int j = 0; j < BW; j++)
        if (i * BW + j < bitq.size()) w[j] = bitq[i * BW + j];
      exp_w.push_back(w);
    end
    exp_tail = bitq.size() - (nw - 1) * BW;

    cyc = 0; stall_lo = slo; stall_hi = shi; have_hold = 1'b0;
    dn_Ready = !(slo <= 0 && shi > 0);
    for (int i = 0; i < nbeats; i++) begin
      up_Vector = beats[i]; up_Valid = 1'b1; up_Last = (i == nbeats - 1);
      to = 0;
      do begin step(a); to++; end while (!a && to < 1000);
      if (!a) begin
        vectors++; miscompares++;
        $error("FAIL %s_accept_timeout: beat %0d not accepted within 1000 cycles", tag, i);
      end
      up_Valid = 1'b0; up_Last = 1'b0;
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) step(a);
    end
    to = 0;
    while (!(got_l.size() > 0 && got_l[got_l.size()-1]) && to < 500) begin step(a); to++; end
    repeat (4) step(a);

    check({tag, "_count"}, BW'(got_w.size()), BW'(exp_w.size()));
    if (exp_count > 0) check({tag, "_count_fixed"}, BW'(got_w.size()), BW'(exp_count));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), got_w[i], exp_w[i]);
      check($sformatf("%s_last%0d", tag, i), BW'(got_l[i]), BW'(i == exp_w.size() - 1));
`ifdef VEC_PACK_KEEP_EN
      check($sformatf("%s_keep%0d", tag, i), BW'(got_k[i]),
            BW'((i == exp_w.size() - 1) ? exp_keep(exp_tail) : {KW{1'b1}}));
`endif
    end
  endtask

  initial begin
    bit a;
    rst = 1'b1; up_Vector = '0; up_Valid = 1'b0; up_Last = 1'b0; dn_Ready = 1'b1;
    cyc = 0; stall_lo = 0; stall_hi = 0; have_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dn_valid", BW'(dn_Valid), '0);
    check("rst_dn_last", BW'(dn_Last), '0);
    check("rst_dn_vector", dn_Vector, '0);
    check("rst_up_ready", BW'(up_Ready), BW'(1));
    check("rst_keep", BW'(dn_Keep_w), '0);
    rst = 1'b0;
    step(a);

    run_stream("s8", 8, 0, 0, 0, 0, 58);
    check("s8_tail_bits", BW'(exp_tail), BW'(64));
    run_stream("s32", 32, 0, 3, 0, 0, 230);
    check("s32_tail_bits", BW'(exp_tail), BW'(BW));
    run_stream("stall", 4, 0, 0, 12, 32, 0);
    run_stream("cut", 1, 4, 0, 0, 0, 4);
    run_stream("after_cut", 1, 0, -1, 0, 0, 8);

    // Park a partial word with downstream blocked, then reset over it.
    stall_lo = 0; stall_hi = 100000; dn_Ready = 1'b0; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      up_Vector = rand_word(); up_Valid = 1'b1; up_Last = 1'b0;
      step(a);
    end
    up_Valid = 1'b0;
    check("pre_rst_valid", BW'(dn_Valid), BW'(1));
    rst = 1'b1;
    step(a);
    check("mid_rst_valid", BW'(dn_Valid), '0);
    check("mid_rst_last", BW'(dn_Last), '0);
    check("mid_rst_vector", dn_Vector, '0);
    check("mid_rst_up_ready", BW'(up_Ready), BW'(1));
    check("mid_rst_keep", BW'(dn_Keep_w), '0);
    rst = 1'b0;
    step(a);
    run_stream("post_rst", 1, 0, 0, 0, 0, 8);

    for (int r = 0; r < 3; r++) begin
      int nv, nbt, lo;
      nv  = $urandom_range(1, 3);
      nbt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, nv * BEATS) : 0;
      lo  = $urandom_range(2, 20);
      run_stream($sformatf("rnd%0d", r), nv, nbt, -1, lo, lo + $urandom_range(0, 15), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
